// File: rtl/kbd_io_pkg.sv
// rtl/kbd_io_pkg.sv - shared types and constants for the PS/2 keyboard I/O port
package kbd_io_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int ST_NE     = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_ERR    = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 7;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver: sync, edge detect, frame FSM, timeout
module ps2_rx_frame
  import kbd_io_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       rx_abort
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // clk_sync[0..1] is the synchronizer, clk_sync[2] the previous stage for edge detect
  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fall;
  logic          dat_smp;

  rx_state_t     state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
      fall     <= 1'b0;
      dat_smp  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= clk_sync[2] & ~clk_sync[1];
      dat_smp  <= dat_sync[1];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    to_cnt_nxt  = to_cnt;
    byte_vld    = 1'b0;
    frame_err   = 1'b0;
    rx_abort    = 1'b0;
    if (state == RX_IDLE) begin
      to_cnt_nxt = '0;
      if (fall && !dat_smp) begin
        state_nxt   = RX_DATA;
        bit_cnt_nxt = '0;
      end
    end else if (fall) begin
      to_cnt_nxt = '0;
      case (state)
        RX_DATA: begin
          shreg_nxt   = {dat_smp, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          par_nxt   = dat_smp;
          state_nxt = RX_STOP;
        end
        RX_STOP: begin
          // good frame needs stop=1 and odd parity over data plus parity bit
          byte_vld  = 1'b1;
          frame_err = ~(dat_smp & (^{shreg, par}));
          state_nxt = RX_IDLE;
        end
        default: state_nxt = RX_IDLE;
      endcase
    end else if (to_cnt == TW'(TIMEOUT)) begin
      state_nxt  = RX_IDLE;
      to_cnt_nxt = '0;
      rx_abort   = 1'b1;
    end else begin
      to_cnt_nxt = to_cnt + TW'(1);
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/kbd_ps2_io.sv
// rtl/kbd_ps2_io.sv - CPU keyboard I/O responder: scancode FIFO, sticky flags, read mux
// Optional break-prefix folding is enabled by defining KBD_BREAK_FILTER_EN.
module kbd_ps2_io
  import kbd_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        io_rdn,
  input  logic        io_sel,
  output logic [31:0] io_data,
  output logic        kbd_rdy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
`ifdef KBD_BREAK_FILTER_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  logic                  byte_vld;
  logic [7:0]            rx_byte;
  logic                  frame_err;

  logic [FW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  err, ovf;
  logic                  empty, full, pop, push_req, push_ok, stat_rd;
  logic [FW-1:0]         push_word, code;
  logic [3:0]            cnt4;
  logic [31:0]           status_word, data_word;

`ifdef KBD_BREAK_FILTER_EN
  logic rx_abort;
  logic is_prefix;
  logic break_pend;
`endif

  ps2_rx_frame #(
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_vld  (byte_vld),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
`ifdef KBD_BREAK_FILTER_EN
    .rx_abort  (rx_abort)
`else
    .rx_abort  ()
`endif
  );

`ifdef KBD_BREAK_FILTER_EN
  assign is_prefix = byte_vld & ~frame_err & (rx_byte == BREAK_PREFIX);
  assign push_req  = byte_vld & ~frame_err & ~is_prefix;
  assign push_word = {break_pend, rx_byte};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                                           break_pend <= 1'b0;
    else if (is_prefix)                                  break_pend <= 1'b1;
    else if (push_req || (byte_vld && frame_err) || rx_abort) break_pend <= 1'b0;
  end
`else
  assign push_req  = byte_vld & ~frame_err;
  assign push_word = rx_byte;
`endif

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = ~io_rdn & ~io_sel & ~empty;
  assign stat_rd = ~io_rdn & io_sel;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign push_ok = push_req & (~full | pop);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push_ok) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      kbd_rdy <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      kbd_rdy <= (count_nxt != '0);
      err     <= (byte_vld & frame_err) | (err & ~stat_rd);
      ovf     <= (push_req & full & ~pop) | (ovf & ~stat_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  assign code = empty ? '0 : mem[rd_ptr];
  assign cnt4 = 4'(count);

  always_comb begin
    status_word                      = '0;
    status_word[ST_NE]               = ~empty;
    status_word[ST_FULL]             = full;
    status_word[ST_OVF]              = ovf;
    status_word[ST_ERR]              = err;
    status_word[ST_CNT_HI:ST_CNT_LO] = cnt4;
  end

`ifdef KBD_BREAK_FILTER_EN
  assign data_word = {22'b0, ~empty, code};
`else
  assign data_word = {23'b0, ~empty, code};
`endif

  assign io_data = io_sel ? status_word : data_word;

endmodule

// File: tb/tb_kbd_ps2_io.sv
// tb/tb_kbd_ps2_io.sv - self-checking bench for kbd_ps2_io (table vectors, corner sequences, random vs model)
module tb_kbd_ps2_io;

  localparam int TO   = 300;
  localparam int HALF = 10;
`ifdef KBD_BREAK_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int VB = FILT ? 9 : 8;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        io_rdn = 1'b1;
  logic        io_sel = 1'b0;
  logic [31:0] io_data;
  logic        kbd_rdy;

  int checks = 0;
  int errors = 0;

  // reference model: queue of stored codes ({brk, byte}) plus sticky flags
  logic [8:0] q[$];
  bit m_err, m_ovf, m_brk;

  always #5 clk = ~clk;

  kbd_ps2_io #(.DEPTH_LOG2(3), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .io_rdn   (io_rdn),
    .io_sel   (io_sel),
    .io_data  (io_data),
    .kbd_rdy  (kbd_rdy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input bit valid, input logic [8:0] c);
    return valid ? ((32'd1 << VB) | 32'(c)) : 32'd0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [3:0] c;
    c = 4'(q.size());
    return {24'b0, c, m_err, m_ovf, (q.size() == 8), (q.size() != 0)};
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err = 1'b1;
      m_brk = 1'b0;
    end else if (FILT && b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (q.size() < 8) q.push_back({m_brk, b});
      else m_ovf = 1'b1;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void m_reset();
    q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_brk = 1'b0;
  endfunction

  task automatic ps2_bit(input logic d);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    send_head(b, bad_par);
    ps2_bit(stop);
    repeat (4) @(negedge clk);
    m_frame(b, !bad_par && stop);
  endtask

  task automatic rd(input logic sel, output logic [31:0] v);
    @(negedge clk);
    io_sel = sel;
    io_rdn = 1'b0;
    #1 v = io_data;
    @(negedge clk);
    io_rdn = 1'b1;
  endtask

  task automatic rd_stat_chk(input string name);
    logic [31:0] v, e;
    e = m_status();
    rd(1'b1, v);
    check(name, v, e);
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic rd_data_chk(input string name);
    logic [31:0] v, e;
    e = (q.size() != 0) ? exp_data(1'b1, q[0]) : 32'd0;
    rd(1'b0, v);
    check(name, v, e);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          stop;
    logic [31:0] st;
    bit          vld;
  } vec_t;

  vec_t vt[6];
  logic [31:0] v;
  logic [7:0] rb;
  int r;

  initial begin
    vt[0] = '{8'h1C, 1'b0, 1'b1, 32'h11, 1'b1};
    vt[1] = '{8'h1C, 1'b1, 1'b1, 32'h08, 1'b0};
    vt[2] = '{8'h1C, 1'b0, 1'b0, 32'h08, 1'b0};
    vt[3] = '{8'h00, 1'b0, 1'b1, 32'h11, 1'b1};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 32'h11, 1'b1};
    vt[5] = '{8'hA5, 1'b1, 1'b1, 32'h08, 1'b0};
    m_reset();

    // reset state
    repeat (3) @(negedge clk);
    io_sel = 1'b0;
    #1 check("rst_data", io_data, 32'd0);
    io_sel = 1'b1;
    #1 check("rst_status", io_data, 32'd0);
    check("rst_kbd_rdy", {31'b0, kbd_rdy}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // single frame: kbd_rdy rises exactly 1 clk after the stop-edge pulse
    send_head(8'h1C, 1'b0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("t1_rdy_early", {31'b0, kbd_rdy}, 32'd0);
    @(posedge clk);
    #1 check("t1_rdy", {31'b0, kbd_rdy}, 32'd1);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    m_frame(8'h1C, 1'b1);
    rd(1'b1, v); check("t1_status", v, 32'h11); m_err = 0; m_ovf = 0;
    rd(1'b0, v); check("t1_data", v, exp_data(1'b1, 9'h01C)); void'(q.pop_front());
    rd(1'b1, v); check("t1_status_after", v, 32'h00);
    #1 check("t1_rdy_after", {31'b0, kbd_rdy}, 32'd0);

    // table vectors: good/bad parity/bad stop frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].b, vt[i].bad_par, vt[i].stop);
      rd(1'b1, v); check($sformatf("vec%0d_status", i), v, vt[i].st);
      m_err = 0; m_ovf = 0;
      rd(1'b0, v); check($sformatf("vec%0d_data", i), v, exp_data(vt[i].vld, {1'b0, vt[i].b}));
      if (q.size() != 0) void'(q.pop_front());
      rd(1'b1, v); check($sformatf("vec%0d_clear", i), v, 32'h00);
    end

    // nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    rd(1'b1, v); check("t2_status_ovf", v, 32'h87);
    rd(1'b1, v); check("t2_status_clr", v, 32'h83);
    m_ovf = 0;
    for (int i = 1; i <= 8; i++) begin
      rd(1'b0, v); check($sformatf("t2_data%0d", i), v, exp_data(1'b1, 9'(i)));
      void'(q.pop_front());
    end
    rd(1'b0, v); check("t2_empty", v, 32'd0);

    // partial frame aborted by timeout, then a good frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    repeat (TO + 10) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    rd(1'b1, v); check("t4_status", v, 32'h11);
    rd(1'b0, v); check("t4_data", v, exp_data(1'b1, 9'h05A)); void'(q.pop_front());

    // push on a full FIFO coinciding with a data read
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1);
    send_head(8'h09, 1'b0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    io_sel = 1'b0;
    io_rdn = 1'b0;
    #1 check("t5_coinc_data", io_data, exp_data(1'b1, 9'h001));
    @(negedge clk);
    io_rdn = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    void'(q.pop_front());
    m_frame(8'h09, 1'b1);
    rd(1'b1, v); check("t5_status", v, 32'h83);
    for (int i = 2; i <= 9; i++) begin
      rd(1'b0, v); check($sformatf("t5_data%0d", i), v, exp_data(1'b1, 9'(i)));
      void'(q.pop_front());
    end

    // reset in mid-frame with a stored entry
    send_frame(8'h33, 1'b0, 1'b1);
    ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b0;
    @(negedge clk);
    clrn = 1'b0;
    io_sel = 1'b1;
    #1 check("t5_rst_status", io_data, 32'd0);
    io_sel = 1'b0;
    #1 check("t5_rst_data", io_data, 32'd0);
    check("t5_rst_rdy", {31'b0, kbd_rdy}, 32'd0);
    repeat (3) @(negedge clk);
    ps2_data = 1'b1;
    clrn = 1'b1;
    m_reset();
    repeat (10) @(negedge clk);
    rd(1'b1, v); check("t5_post_rst_status", v, 32'h00);
    send_frame(8'h29, 1'b0, 1'b1);
    rd(1'b0, v); check("t5_data29", v, exp_data(1'b1, 9'h029)); void'(q.pop_front());

    // break prefix followed by a make code
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    rd_stat_chk("t6_status");
    rd_data_chk("t6_data0");
    rd_data_chk("t6_data1");
    rd_data_chk("t6_data2");

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        rb = 8'($urandom);
        if ($urandom_range(0, 7) == 0) rb = 8'hF0;
        case ($urandom_range(0, 9))
          0:       send_frame(rb, 1'b1, 1'b1);
          1:       send_frame(rb, 1'b0, 1'b0);
          default: send_frame(rb, 1'b0, 1'b1);
        endcase
      end else if (r < 8) begin
        rd_data_chk($sformatf("rnd%0d_data", it));
      end else begin
        rd_stat_chk($sformatf("rnd%0d_status", it));
        check($sformatf("rnd%0d_rdy", it), {31'b0, kbd_rdy}, {31'b0, (q.size() != 0)});
      end
    end
    for (int i = 0; i < 9; i++) rd_data_chk($sformatf("drain%0d", i));
    rd_stat_chk("drain_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_ps2_io.md
Name: kbd_ps2_io

Overview:
- I/O-space responder for the CPU's keyboard port.
- Receives PS/2 device-to-host frames, buffers scancodes in a FIFO and answers CPU reads combinationally.
- Pops the FIFO on the clock edge that ends a data read.
- Sits in I/O space a0000000-bfffffff, driven by the CPU's io_rdn strobe and address bit 2.

Parameters:
- DEPTH_LOG2, 3: FIFO depth is 2**DEPTH_LOG2 entries; legal range 1..3, because count must fit in 4 status bits.
- TIMEOUT, 50000: clk cycles without a PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- io_rdn  in  1  active-low CPU I/O read strobe, valid for one clk cycle.
- io_sel  in  1  CPU address bit 2: 0 = data register, 1 = status register.
- io_data  out  32  read data; combinational from io_sel and internal state.
- kbd_rdy  out  1  FIFO not empty, registered.

Behaviour:
- Reset: clrn is asynchronous and active-low; the clock is clk.
  - While clrn is low: FSM to IDLE, FIFO pointers and count to 0, sticky flags cleared, synchronizers set to 1, kbd_rdy=0.
  - io_data then reads 0 for both io_sel values.
  - Reset in mid-frame discards the partial frame.
- Input sync: ps2_clk and ps2_data pass through 2-flop synchronizers.
  - A falling edge is detected when the sync stage is 0 and the previous stage is 1, as a registered pulse.
  - Pin-to-edge latency is 3 clk. ps2_data is sampled on the edge pulse.
- Frame FSM (one step per falling-edge pulse):
  - IDLE: data=0 goes to DATA with bit counter 0; data=1 is ignored and stays in IDLE.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Good frame: push the byte.
    - Bad frame: drop the byte and set sticky err.
    - Either way, return to IDLE.
- Timeout: in any state except IDLE, a counter increments every clk and reloads on each edge pulse.
  - When it reaches TIMEOUT, go to IDLE and discard the frame. err is not set.
- FIFO push: occurs on the clk edge on which the STOP step completes.
  - kbd_rdy and count update on the same edge, so they are visible 1 clk after the stop-bit edge pulse.
- FIFO pop: occurs on the clk edge while io_rdn=0, io_sel=0 and count>0. A data read with the FIFO empty does nothing.
- Full: a push while full is dropped and sets sticky ovf, unless a pop occurs on the same edge.
  - In that case both the pop and the push are done and count stays at the maximum.
- Simultaneous push and pop when not full: count is unchanged. Pointers wrap modulo the depth.
- Data read (io_sel=0):
  - io_data = {23'b0, valid, code[7:0]}, where valid = count>0 and code = FIFO head.
  - Reads 0 when the FIFO is empty.
- Status read (io_sel=1):
  - io_data = {24'b0, count[3:0], err, ovf, full, not_empty}.
  - With io_rdn=0, ovf and err clear on that clk edge.
  - A flag set on the same edge takes priority over the clear.
- io_rdn=1: no state change; io_data still shows the current value.

Optional Feature:
- KBD_BREAK_FILTER_EN defined:
  - A good 0xF0 byte is not pushed; it sets break_pend.
  - The next good byte is pushed with bit 8 set. FIFO width becomes 9 bits.
  - Data read returns {22'b0, valid, brk, code}.
  - break_pend is cleared by push, timeout, bad frame or reset.
- Undefined: every good byte, including 0xF0, is pushed. Bit 9 of io_data reads 0.

Decomposition:
- Package kbd_io_pkg holds:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Status bit positions (NE=0, FULL=1, OVF=2, ERR=3, CNT=7:4).
  - The break prefix constant 8'hF0.
- One sub-module, ps2_rx_frame: synchronizers, edge detect, FSM and timeout.
  - Outputs a 1-clk byte_vld pulse with byte and frame_err.
- The FIFO, flags and read mux stay in kbd_ps2_io.

Test Plan:
1. Frame 0x1C, parity 0, stop 1 -> kbd_rdy rises 1 clk after the stop edge; status=0x11; data read=0x11C and pops; status=0x00, kbd_rdy=0.
2. Nine frames 0x01..0x09, no reads -> status=0x87; next status read returns 0x87, then 0x83; eight data reads return 0x101..0x108, then 0x000.
3. Frame 0x1C with parity 1 -> no push; status=0x08; after that read, status=0x00. Repeat with stop=0 -> same result.
4. Start bit plus 3 data bits, idle TIMEOUT+10 clk, then a full frame 0x5A -> one entry; data read=0x15A; err=0.
5. Stop edge of the 9th frame coinciding with a data read while full -> count stays 8, ovf=0, the new byte is last out. Separately, clrn low mid-frame -> status=0x00, and the next full frame 0x29 reads 0x129.
6. Frames 0xF0, 0x1C -> with KBD_BREAK_FILTER_EN: one entry, data=0x31C; without: two entries, 0x1F0 then 0x11C.
